// File: rtl/lenet_argmax.sv
// Serial argmax over the 10-class LeNet score vector, one score per cycle.
// Reports winning digit, winning score and saturated margin to the runner-up.
module lenet_argmax #(
   parameter int bitwidth = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [bitwidth-1:0] scores [10],
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 class_id,
   output logic signed [bitwidth-1:0] max_score,
   output logic [bitwidth-1:0]        margin
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic signed [bitwidth-1:0] MIN_VAL = {1'b1, {(bitwidth-1){1'b0}}};
   localparam logic [bitwidth-1:0]        MAX_POS = {1'b0, {(bitwidth-1){1'b1}}};

   state_t                      state_q, state_d;
   logic [3:0]                  idx_q, idx_d;
   logic signed [bitwidth-1:0]  buf_q [10];
   logic signed [bitwidth-1:0]  buf_d [10];
   logic signed [bitwidth-1:0]  best_q, best_d, second_q, second_d;
   logic [3:0]                  id_q, id_d;
   logic                        out_valid_q, out_valid_d;
   logic [3:0]                  class_id_q, class_id_d;
   logic signed [bitwidth-1:0]  max_score_q, max_score_d;
   logic [bitwidth-1:0]         margin_q, margin_d;

   logic signed [bitwidth-1:0]  cur_s, best_n, second_n;
   logic [3:0]                  id_n;
   logic signed [bitwidth:0]    diff_s;
   logic [bitwidth-1:0]         margin_n;

   // Running best/runner-up update for the current index; ties keep the lower index.
   always_comb begin
      cur_s    = buf_q[idx_q];
      best_n   = best_q;
      second_n = second_q;
      id_n     = id_q;
      if (idx_q == 4'd0) begin
         best_n   = cur_s;
         second_n = MIN_VAL;
         id_n     = 4'd0;
      end else if (cur_s > best_q) begin
         second_n = best_q;
         best_n   = cur_s;
         id_n     = idx_q;
      end else if (cur_s > second_q) begin
         second_n = cur_s;
      end else begin
         second_n = second_q;
      end
      // best >= second always holds, so only the upper positive bound needs clamping
      diff_s = {best_n[bitwidth-1], best_n} - {second_n[bitwidth-1], second_n};
      if (diff_s[bitwidth:bitwidth-1] != 2'b00) begin
         margin_n = MAX_POS;
      end else begin
         margin_n = diff_s[bitwidth-1:0];
      end
   end

   // Next-state and result-register logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      buf_d       = buf_q;
      best_d      = best_q;
      second_d    = second_q;
      id_d        = id_q;
      out_valid_d = out_valid_q;
      class_id_d  = class_id_q;
      max_score_d = max_score_q;
      margin_d    = margin_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               buf_d   = scores;
               idx_d   = 4'd0;
               state_d = SCAN;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            best_d   = best_n;
            second_d = second_n;
            id_d     = id_n;
            if (idx_q == 4'd9) begin
               idx_d       = 4'd0;
               state_d     = DONE;
               out_valid_d = 1'b1;
               class_id_d  = id_n;
               max_score_d = best_n;
               margin_d    = margin_n;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         for (int i = 0; i < 10; i++) buf_q[i] <= {bitwidth{1'b0}};
         best_q      <= {bitwidth{1'b0}};
         second_q    <= {bitwidth{1'b0}};
         id_q        <= 4'd0;
         out_valid_q <= 1'b0;
         class_id_q  <= 4'd0;
         max_score_q <= {bitwidth{1'b0}};
         margin_q    <= {bitwidth{1'b0}};
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         buf_q       <= buf_d;
         best_q      <= best_d;
         second_q    <= second_d;
         id_q        <= id_d;
         out_valid_q <= out_valid_d;
         class_id_q  <= class_id_d;
         max_score_q <= max_score_d;
         margin_q    <= margin_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign class_id  = class_id_q;
   assign max_score = max_score_q;
   assign margin    = margin_q;

endmodule

// File: tb/tb_lenet_argmax.sv
// Directed self-checking bench for lenet_argmax: results, latency, ties,
// saturation, backpressure and reset abort.
module tb_lenet_argmax;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] scores [10];
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         class_id;
   logic signed [31:0] max_score;
   logic [31:0]        margin;

   int checks = 0;
   int errors = 0;

   lenet_argmax #(.bitwidth(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .scores(scores), .out_valid(out_valid), .out_ready(out_ready),
      .class_id(class_id), .max_score(max_score), .margin(margin)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic load(input int v [10]);
      for (int i = 0; i < 10; i++) scores[i] = v[i];
   endtask

   task automatic scramble();
      for (int i = 0; i < 10; i++) scores[i] = 32'sd1000 + i;
   endtask

   // Called at a negedge while IDLE; returns at the negedge after the accept edge.
   task automatic start_vec(input int v [10]);
      load(v);
      in_valid = 1'b1;
      #1 chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      scramble();
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_vec(input string tag, input int v [10], input int eid,
                          input int emax, input int emargin);
      int n;
      out_ready = 1'b1;
      start_vec(v);
      wait_valid(n);
      chk({tag, "_latency"}, n, 32'd10);
      chk({tag, "_class_id"}, {28'd0, class_id}, eid);
      chk({tag, "_max_score"}, max_score, emax);
      chk({tag, "_margin"}, margin, emargin);
      @(negedge clk);
      chk({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int v [10];
      int n;
      int bad;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) scores[i] = 32'sd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_class_id", {28'd0, class_id}, 32'd0);
      chk("rst_max_score", max_score, 32'd0);
      chk("rst_margin", margin, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      v = '{3, -1, 7, 2, 0, 5, -8, 1, 6, 4};
      run_vec("basic", v, 2, 7, 1);
      v = '{9, 0, 0, 0, 9, 0, 0, 0, 0, 0};
      run_vec("tie", v, 0, 9, 0);
      v = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -5};
      run_vec("last", v, 9, -5, 95);
      v[0] = 2147483647;
      for (int i = 1; i < 10; i++) v[i] = -2147483647 - 1;
      run_vec("sat", v, 0, 2147483647, 2147483647);

      // Backpressure with a new vector waiting on in_valid.
      out_ready = 1'b0;
      v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      start_vec(v);
      wait_valid(n);
      chk("bp_latency", n, 32'd10);
      v = '{0, 50, -20, 40, 10, 0, 0, 0, 0, 0};
      load(v);
      in_valid = 1'b1;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid !== 1'b1 || class_id !== 4'd9 || max_score !== 32'sd10 ||
             margin !== 32'd1 || in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("bp_hold_bad_cycles", bad, 32'd0);
      chk("bp_class_id", {28'd0, class_id}, 32'd9);
      out_ready = 1'b1;
      #1 chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("bp_in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
      chk("bp_out_valid_after_xfer", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_new_accepted", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      scramble();
      wait_valid(n);
      chk("bp2_latency", n, 32'd10);
      chk("bp2_class_id", {28'd0, class_id}, 32'd1);
      chk("bp2_max_score", max_score, 32'd50);
      chk("bp2_margin", margin, 32'd10);
      @(negedge clk);

      // Reset asserted while idx 5 is being scanned.
      v = '{-9, 1, 2, 3, 4, 70, 6, 7, 8, 9};
      start_vec(v);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1 chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_class_id", {28'd0, class_id}, 32'd0);
      chk("abort_max_score", max_score, 32'd0);
      chk("abort_margin", margin, 32'd0);
      bad = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      chk("abort_no_result", bad, 32'd0);

      v = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
      run_vec("after_rst", v, 0, -1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
